// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the serial pattern-detection run controller.
package seq_ctrl_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int LEN_W           = $clog2(DEFAULT_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_cmp.sv
// History shift register, saturating fill counter and length-masked pattern compare.
// Build option OVERLAP_EN keeps the fill count after a hit so overlapping matches count.
module seq_shift_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               data,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] history_q, history_d, hist_shift, mask;
  logic [LEN_W-1:0]   seen_q, seen_d, seen_inc;

  // Only the newest len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len);
    end
  endgenerate

  assign hist_shift = {history_q[MAX_LEN-2:0], data};
  assign seen_inc   = (seen_q == LEN_W'(MAX_LEN)) ? seen_q : seen_q + 1'b1;
  assign hit        = shift_en && (seen_inc >= len) &&
                      ((hist_shift & mask) == (pattern & mask));

  always_comb begin
    history_d = history_q;
    seen_d    = seen_q;
    if (clr) begin
      history_d = '0;
      seen_d    = '0;
    end else if (shift_en) begin
      history_d = hist_shift;
`ifdef OVERLAP_EN
      seen_d    = seen_inc;
`else
      seen_d    = hit ? '0 : seen_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      seen_q    <= '0;
    end else begin
      history_q <= history_d;
      seen_q    <= seen_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Windowed, software-configurable serial pattern match counter (FSM IDLE/RUN/DONE).
// Build option OVERLAP_EN selects overlapping match counting in seq_shift_cmp.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic [WIN_W-1:0]             win_len,
  input  logic                         abort,
  input  logic                         data,
  input  logic                         data_valid,
  output logic                         flag,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               loaded_q, loaded_d;
  logic               cfg_err_q, cfg_err_d;
  logic [WIN_W-1:0]   win_q, win_d, bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               flag_q, flag_d;
  logic               clr, shift_en, hit, len_ok;

  // abort wins over a simultaneous bit, so that bit never reaches the history.
  assign shift_en    = (state_q == RUN) && data_valid && !abort;
  assign clr         = (state_q == IDLE) && start && loaded_q;
  assign len_ok      = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  seq_shift_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LW)) u_shift_cmp (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .data     (data),
    .pattern  (pattern_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    loaded_d    = loaded_q;
    cfg_err_d   = 1'b0;
    win_d       = win_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    flag_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (len_ok) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            loaded_d  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (clr) begin
          win_d       = win_len;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          state_d     = (win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (data_valid) begin
          bit_cnt_d = bit_cnt_inc;
          if (hit) begin
            flag_d = 1'b1;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
          end
          if (bit_cnt_inc == win_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      loaded_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      win_q       <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      cfg_err_q   <= cfg_err_d;
      win_q       <= win_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      flag_q      <= flag_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign flag      = flag_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl; expectations are hand-derived.
module tb_seq_detect_ctrl;

`ifdef OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        abort = 1'b0;
  logic        data = 1'b0;
  logic        data_valid = 1'b0;
  logic        flag;
  logic [7:0]  match_cnt;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_err     (cfg_err),
    .start       (start),
    .win_len     (win_len),
    .abort       (abort),
    .data        (data),
    .data_valid  (data_valid),
    .flag        (flag),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (obs === exp) $display("check %-14s = %0h", tag, obs);
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic start_win(input logic [15:0] w);
    start = 1'b1; win_len = w;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    data = b; data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
  endtask

  logic [9:0] stream1;
  logic [5:0] stream2;
  logic [5:0] flags2;

  initial begin
    // ---- reset state ----
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_flag", flag, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);

    // ---- start without config is ignored ----
    start_win(16'd5);
    chk("nocfg_busy", busy, 0);
    cyc();
    chk("nocfg_busy2", busy, 0);

    // ---- invalid lengths pulse cfg_err, valid config kept ----
    configure(8'h00, 4'd0);
    chk("len0_err", cfg_err, 1);
    cyc();
    chk("len0_err_end", cfg_err, 0);
    configure(8'b0001_0111, 4'd5);
    chk("len5_err", cfg_err, 0);
    configure(8'hFF, 4'd9);
    chk("len9_err", cfg_err, 1);
    cyc();
    chk("len9_err_end", cfg_err, 0);

    // ---- pattern 10111, window 10, stream 1011101111 ----
    start_win(16'd10);
    chk("w10_busy", busy, 1);
    chk("w10_ready", cfg_ready, 0);
    chk("w10_cnt0", match_cnt, 0);
    stream1 = 10'b1011101111;
    for (int i = 1; i <= 10; i++) begin
      send_bit(stream1[10-i]);
      chk($sformatf("w10_flag_b%0d", i), flag,
          (i == 5) ? 1 : ((i == 9) ? 32'(OVL) : 0));
      if (i == 9) chk("w10_done_b9", done, 0);
    end
    chk("w10_done", done, 1);
    chk("w10_cnt", match_cnt, OVL ? 2 : 1);
    cyc();
    chk("w10_done_end", done, 0);
    chk("w10_busy_end", busy, 0);
    chk("w10_cnt_hold", match_cnt, OVL ? 2 : 1);

    // ---- zero-length window ----
    start_win(16'd0);
    chk("w0_done", done, 1);
    chk("w0_cnt", match_cnt, 0);
    cyc();
    chk("w0_done_end", done, 0);
    chk("w0_busy_end", busy, 0);

    // ---- abort beats a matching last bit; config ignored in RUN ----
    configure(8'b11, 4'd2);
    start_win(16'd3);
    send_bit(1'b1);
    chk("ab_flag1", flag, 0);
    cfg_valid = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'h00;
    send_bit(1'b1);
    cfg_valid = 1'b0;
    chk("ab_flag2", flag, 1);
    chk("ab_cnt2", match_cnt, 1);
    cyc();
    chk("ab_run_err", cfg_err, 0);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_flag", flag, 0);
    chk("ab_done", done, 0);
    chk("ab_cnt", match_cnt, 1);
    cyc();
    chk("ab_done2", done, 0);

    // ---- valid only every 3rd cycle, pattern 10 ----
    configure(8'b10, 4'd2);
    start_win(16'd6);
    stream2 = 6'b101100;
    flags2  = 6'b010010;
    for (int i = 1; i <= 6; i++) begin
      send_bit(stream2[6-i]);
      chk($sformatf("gap_flag_b%0d", i), flag, 32'(flags2[6-i]));
      if (i < 6) begin
        for (int g = 0; g < 2; g++) begin
          data = ~stream2[6-i];
          cyc();
          chk($sformatf("gap_idle_b%0d", i), flag, 0);
        end
      end
    end
    chk("gap_done", done, 1);
    chk("gap_cnt", match_cnt, 2);
    cyc();

    // ---- counter saturation over 300 ones ----
    configure(8'b1, 4'd1);
    start_win(16'd300);
    for (int i = 1; i <= 300; i++) begin
      send_bit(1'b1);
      if (i == 254) chk("sat_cnt254", match_cnt, 254);
      if (i == 299) chk("sat_done299", done, 0);
    end
    chk("sat_done300", done, 1);
    chk("sat_flag300", flag, 1);
    chk("sat_cnt", match_cnt, 255);
    cyc();
    chk("sat_busy_end", busy, 0);

    // ---- reset mid-window drops everything, config included ----
    start_win(16'd10);
    send_bit(1'b1);
    chk("mid_flag", flag, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_cnt", match_cnt, 0);
    chk("mid_flag0", flag, 0);
    start_win(16'd2);
    chk("mid_nocfg", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for serial pattern detection. It accepts a programmable bit pattern of 1 to MAX_LEN bits and then, on `start`, arms a detection window of `win_len` valid input bits. It counts pattern matches in the serial stream and ends the window with a one-cycle `done` pulse. It sits between the software-visible configuration registers and the serial data path, and turns the fixed-pattern detector into a configurable, windowed measurement.

## Interface
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 8: width of the match counter.
- WIN_W, 16: width of the window length.

- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted; equals (state == IDLE).
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; valid range 1..MAX_LEN.
- cfg_err  out  1  one-cycle pulse when an offered cfg_len is invalid.
- start  in  1  begin a window; sampled in IDLE only.
- win_len  in  WIN_W  window length in valid bits; sampled together with start.
- abort  in  1  cancel the window from RUN.
- data  in  1  serial bit.
- data_valid  in  1  `data` is qualified this cycle.
- flag  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  number of matches in the current or last window.
- busy  out  1  (state != IDLE).
- done  out  1  one-cycle window-complete pulse.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: pattern 0, len 0, cfg_loaded 0, history 0, bits_seen 0, bit_cnt 0, flag 0, match_cnt 0, done 0, cfg_err 0.
- Config handshake: when cfg_valid & cfg_ready:
  - If cfg_len is in 1..MAX_LEN, latch pattern and len and set cfg_loaded.
  - Otherwise pulse cfg_err on the next cycle and keep the old configuration.
  - Outside IDLE, offered configurations are ignored. No error is raised.
- IDLE → RUN: on start & cfg_loaded, latch win_len, clear history, bits_seen, bit_cnt and match_cnt. start without cfg_loaded is ignored.
- IDLE → DONE: on start & cfg_loaded with win_len == 0. No bits are consumed; match_cnt becomes 0.
- RUN, each cycle with data_valid:
  - history ← {history[MAX_LEN-2:0], data}.
  - bits_seen increments, saturating at MAX_LEN.
  - bit_cnt increments.
- Match condition: updated bits_seen ≥ len and updated history[len-1:0] == pattern[len-1:0].
- On a match: flag=1 on the next cycle, and match_cnt increments, saturating at 2^CNT_W−1.
- data_valid low: state holds and nothing changes.
- RUN → DONE: when the accepted bit brings bit_cnt to win_len. A match on that last bit is still counted and flagged.
- RUN → IDLE: when abort is high. abort beats a simultaneous last bit: no done, and the last bit is neither counted nor flagged. match_cnt holds its partial value.
- DONE → IDLE: unconditionally after one cycle. done=1 while in DONE. match_cnt holds until the next accepted start.

## Timing
- flag has a latency of 1 cycle from the matching data_valid edge.
- done is asserted 1 cycle after the final bit is accepted, and lasts exactly 1 cycle.
- busy goes high the cycle after start is accepted and drops the cycle after DONE.
- cfg_ready is low during RUN and DONE.
- Reset mid-window returns the block to IDLE next cycle with every output at its reset value. Configuration is lost.

## Configuration
- OVERLAP_EN defined: history is kept after a match, so overlapping matches are counted.
- OVERLAP_EN undefined: on a match, bits_seen is cleared to 0. The next match needs len fresh bits (non-overlapping).

## Structure
- Package seq_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the MAX_LEN default;
  - LEN_W = $clog2(MAX_LEN+1).
- Sub-module seq_shift_cmp holds the history shift register, the bits_seen saturation and the masked length compare. It outputs the combinational hit signal. The FSM, counters and handshakes stay in the top level.

## Test plan
- Pattern 10111, len 5, win_len 10, stream 1011101111: with OVERLAP_EN, match_cnt=2 and flag after bits 5 and 9; without OVERLAP_EN, match_cnt=1.
- cfg_len=0, then cfg_len=9: cfg_err pulses each time and the prior config is kept. start before any valid config: busy stays 0.
- win_len=0 with valid config: DONE after 1 cycle, done pulses, match_cnt=0.
- Pattern 1, len 1, win_len 300, all ones, CNT_W=8: match_cnt saturates at 255 and done follows bit 300.
- abort on the same cycle as a matching last bit: returns to IDLE with no done, no flag, and match_cnt unchanged. cfg_valid asserted during RUN is ignored.
- data_valid gaps (valid every 3rd cycle) with pattern 10, len 2: matches and counts are identical to a gap-free stream, and flag occurs only after valid bits.
